// File: rtl/rib_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rib_timer_pkg
//  Description : Shared constants and types for the RIB slave-3 timer.
//                Register offsets (low byte of the slave-local address), CTRL
//                bit positions, interconnect base nibble, bus strobe levels
//                and the CTRL register layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package rib_timer_pkg;

  // Bus-level constants shared with the rest of the RIB fabric
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  // Interconnect decode nibble for this slave (base 0x30000000)
  localparam logic [3:0]  SLAVE_3       = 4'b0011;

  // Register offsets
  localparam logic [7:0]  TIMER_CTRL     = 8'h00;
  localparam logic [7:0]  TIMER_COUNT    = 8'h04;
  localparam logic [7:0]  TIMER_VALUE    = 8'h08;
  localparam logic [7:0]  TIMER_PRESCALE = 8'h0C;

  // CTRL bit indices
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_INTEN_BIT = 1;
  localparam int CTRL_PEND_BIT  = 2;
  localparam int CTRL_PER_BIT   = 3;

  // CTRL register fields, packed so that the bit order matches the indices
  typedef struct packed {
    logic periodic;
    logic pending;
    logic int_en;
    logic enable;
  } ctrl_t;

  // Full 32-bit read view of CTRL; upper bits read as zero
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {28'h0000000, c};
  endfunction

endpackage : rib_timer_pkg
`default_nettype wire

// File: rtl/rib_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rib_timer
//  Description : Memory-mapped 32-bit timer on the RIB slave side (slave 3).
//                Prescaled up-counter with compare/expire, one-shot or
//                periodic mode, and a level interrupt.
//  Ports       : clk     - single clock, rising edge
//                rst     - synchronous active-high reset
//                wraddr  - read/write address, only [7:2] decoded
//                wdata   - write data
//                we      - write strobe, commits at the next rising edge
//                rdata   - combinational read data (registered state only)
//                int_sig - level interrupt = pending & int_en
//  Revision    : 1.0 - initial release
// ============================================================================
module rib_timer
  import rib_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wraddr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        int_sig
);

  // Word offsets (byte offset with the two ignored LSBs removed)
  localparam logic [5:0] OFF_CTRL     = TIMER_CTRL[7:2];
  localparam logic [5:0] OFF_COUNT    = TIMER_COUNT[7:2];
  localparam logic [5:0] OFF_VALUE    = TIMER_VALUE[7:2];
  localparam logic [5:0] OFF_PRESCALE = TIMER_PRESCALE[7:2];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ctrl_t       ctrl_q,  ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] value_q, value_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] psc_q,   psc_d;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [5:0] w_off;
  logic       w_wr;
  logic       w_wr_ctrl;
  logic       w_wr_count;
  logic       w_wr_value;
  logic       w_wr_presc;
  logic       w_unused_addr;

  assign w_off      = wraddr[7:2];
  assign w_wr       = (we == WRITE_ENABLE);
  assign w_wr_ctrl  = w_wr && (w_off == OFF_CTRL);
  assign w_wr_count = w_wr && (w_off == OFF_COUNT);
  assign w_wr_value = w_wr && (w_off == OFF_VALUE);
  assign w_wr_presc = w_wr && (w_off == OFF_PRESCALE);

  // Upper nibble is already stripped by the interconnect, the remaining
  // high bits and the byte-lane bits carry no meaning for word registers.
  assign w_unused_addr = ^{wraddr[31:8], wraddr[1:0]};

  // --------------------------------------------------------------------------
  // Prescaler tick and compare
  // --------------------------------------------------------------------------
  logic w_tick;
  logic w_expire;

  assign w_tick   = ctrl_q.enable && (psc_q == presc_q);
  assign w_expire = w_tick && (count_q == value_q);

  // --------------------------------------------------------------------------
  // Next-state logic. Hardware effects are applied first and software writes
  // afterwards, so a software write to COUNT or to CTRL.enable overrides the
  // hardware update in the same cycle. Pending is the exception: an expire
  // must never be lost, so the W1C is suppressed on an expire cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    value_d = value_q;
    presc_d = presc_q;
    psc_d   = psc_q;

    // Prescaler: parked at zero while disabled. A PRESCALE written below the
    // current psc count simply lets psc run on through 0xFFFF and wrap.
    if (!ctrl_q.enable || w_tick) begin
      psc_d = 16'h0000;
    end else begin
      psc_d = psc_q + 16'h0001;
    end

    // Counter and expire
    if (w_expire) begin
      count_d        = ZERO_WORD;
      ctrl_d.pending = 1'b1;
      if (!ctrl_q.periodic) begin
        ctrl_d.enable = 1'b0;
      end
    end else if (w_tick) begin
      count_d = count_q + 32'd1;
    end

    // Software writes
    if (w_wr_ctrl) begin
      ctrl_d.enable   = wdata[CTRL_EN_BIT];
      ctrl_d.int_en   = wdata[CTRL_INTEN_BIT];
      ctrl_d.periodic = wdata[CTRL_PER_BIT];
      if (wdata[CTRL_PEND_BIT] && !w_expire) begin
        ctrl_d.pending = 1'b0;
      end
    end

    if (w_wr_count) begin
      count_d = wdata;
    end

    if (w_wr_value) begin
      value_d = wdata;
    end

    if (w_wr_presc) begin
      presc_d = wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      count_q <= ZERO_WORD;
      value_q <= ZERO_WORD;
      presc_q <= 16'h0000;
      psc_q   <= 16'h0000;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      value_q <= value_d;
      presc_q <= presc_d;
      psc_q   <= psc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: reflects state as of the last edge, never the in-flight write
  // --------------------------------------------------------------------------
  always_comb begin
    rdata = ZERO_WORD;
    case (w_off)
      OFF_CTRL:     rdata = ctrl_word(ctrl_q);
      OFF_COUNT:    rdata = count_q;
      OFF_VALUE:    rdata = value_q;
      OFF_PRESCALE: rdata = {16'h0000, presc_q};
      default:      rdata = ZERO_WORD;
    endcase
  end

  // Interrupt is purely a function of registered state
  assign int_sig = ctrl_q.pending & ctrl_q.int_en;

endmodule : rib_timer
`default_nettype wire

// File: tb/tb_rib_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rib_timer
//  Description : Self-checking bench for rib_timer: register table, directed
//                multi-cycle timing sequences and a randomized phase checked
//                against a register-file style reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rib_timer;

  logic        clk;
  logic        rst;
  logic [31:0] wraddr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        int_sig;

  int n_checks = 0;
  int n_err    = 0;

  rib_timer dut (
    .clk     (clk),
    .rst     (rst),
    .wraddr  (wraddr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .int_sig (int_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_COUNT = 32'h04;
  localparam logic [31:0] A_VALUE = 32'h08;
  localparam logic [31:0] A_PSC   = 32'h0C;

  // --------------------------------------------------------------------------
  // Reference model: four-word register file updated once per edge.
  // Index 0 CTRL, 1 COUNT, 2 VALUE, 3 PRESCALE. m_psc is the hidden prescaler.
  // --------------------------------------------------------------------------
  logic [31:0] m_reg [4] = '{default: 32'h0};
  logic [15:0] m_psc     = 16'h0;

  logic [31:0] t_reg [4];
  logic [15:0] t_psc;
  logic        t_tick, t_hit;
  int          t_idx;

  always @(posedge clk) begin
    if (rst) begin
      m_reg <= '{default: 32'h0};
      m_psc <= 16'h0;
    end else begin
      t_reg  = m_reg;
      t_tick = m_reg[0][0] && (m_psc == m_reg[3][15:0]);
      t_hit  = t_tick && (m_reg[1] == m_reg[2]);
      t_psc  = (!m_reg[0][0] || t_tick) ? 16'h0 : m_psc + 16'h1;
      if (t_tick) t_reg[1] = t_hit ? 32'h0 : m_reg[1] + 32'h1;
      if (t_hit) begin
        t_reg[0][2] = 1'b1;
        if (!m_reg[0][3]) t_reg[0][0] = 1'b0;
      end
      t_idx = int'(wraddr[7:2]);
      if (we && t_idx < 4) begin
        case (t_idx)
          0: t_reg[0] = {28'h0, wdata[3], t_hit | (m_reg[0][2] & ~wdata[2]),
                         wdata[1], wdata[0]};
          1: t_reg[1] = wdata;
          2: t_reg[2] = wdata;
          default: t_reg[3] = {16'h0, wdata[15:0]};
        endcase
      end
      m_reg <= t_reg;
      m_psc <= t_psc;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int i;
    i = int'(a[7:2]);
    return (i < 4) ? m_reg[i] : 32'h0;
  endfunction

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wraddr = a;
    wdata  = d;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we     = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string nm);
    wraddr = a;
    #1;
    chk(nm, rdata, e);
  endtask

  task automatic int_chk(input logic e, input string nm);
    chk(nm, {31'h0, int_sig}, {31'h0, e});
  endtask

  // --------------------------------------------------------------------------
  // Register access table (timer kept disabled throughout)
  // --------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vtab [12];

  initial begin
    rst    = 1'b1;
    we     = 1'b0;
    wraddr = 32'h0;
    wdata  = 32'h0;

    vtab[0]  = '{1'b0, 32'h0, 32'h0, A_CTRL,       32'h0};
    vtab[1]  = '{1'b0, 32'h0, 32'h0, A_COUNT,      32'h0};
    vtab[2]  = '{1'b0, 32'h0, 32'h0, A_VALUE,      32'h0};
    vtab[3]  = '{1'b0, 32'h0, 32'h0, A_PSC,        32'h0};
    vtab[4]  = '{1'b0, 32'h0, 32'h0, 32'h10,       32'h0};
    vtab[5]  = '{1'b1, A_PSC,   32'h1234_ABCD, A_PSC,   32'h0000_ABCD};
    vtab[6]  = '{1'b1, A_VALUE, 32'hCAFE_F00D, A_VALUE, 32'hCAFE_F00D};
    vtab[7]  = '{1'b1, A_COUNT, 32'h8000_0001, A_COUNT, 32'h8000_0001};
    vtab[8]  = '{1'b1, A_CTRL,  32'hFFFF_FFFA, A_CTRL,  32'h0000_000A};
    vtab[9]  = '{1'b1, 32'h10,  32'h5555_5555, 32'h10,  32'h0};
    vtab[10] = '{1'b1, 32'h0AB0_0009, 32'h0000_0077, A_VALUE, 32'h0000_0077};
    vtab[11] = '{1'b0, 32'h0, 32'h0, 32'h0F00_000F, 32'h0000_ABCD};

    tick_n(3);
    rst = 1'b0;
    int_chk(1'b0, "reset_int");

    for (int i = 0; i < 12; i++) begin
      if (vtab[i].wr) do_write(vtab[i].addr, vtab[i].data);
      else            tick_n(1);
      rd_chk(vtab[i].raddr, vtab[i].exp, $sformatf("table_%0d", i));
    end

    // One-shot: PRESCALE=0, VALUE=3 -> expire 4 edges after enable
    do_write(A_PSC, 32'h0);
    do_write(A_VALUE, 32'h3);
    do_write(A_COUNT, 32'h0);
    do_write(A_CTRL, 32'h3);
    for (int k = 1; k <= 4; k++) begin
      tick_n(1);
      int_chk(k == 4, $sformatf("oneshot_int_k%0d", k));
    end
    rd_chk(A_COUNT, 32'h0, "oneshot_count");
    rd_chk(A_CTRL,  32'h6, "oneshot_ctrl");
    do_write(A_CTRL, 32'h4);
    rd_chk(A_CTRL, 32'h0, "oneshot_w1c");

    // Periodic: PRESCALE=1, VALUE=2 -> expire every 6 edges
    do_write(A_PSC, 32'h1);
    do_write(A_VALUE, 32'h2);
    do_write(A_COUNT, 32'h0);
    do_write(A_CTRL, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      tick_n(1);
      rd_chk(A_COUNT, 32'((k / 2) % 3), $sformatf("per_count_k%0d", k));
      rd_chk(A_CTRL, (k >= 6) ? 32'hF : 32'hB, $sformatf("per_ctrl_k%0d", k));
    end
    int_chk(1'b1, "per_int_high");
    do_write(A_CTRL, 32'hF);
    int_chk(1'b0, "per_int_dropped");
    rd_chk(A_CTRL, 32'hB, "per_ctrl_cleared");
    do_write(A_CTRL, 32'h4);

    // Conflict A: COUNT write on the expire edge wins over the reset-to-zero
    do_write(A_PSC, 32'h0);
    do_write(A_VALUE, 32'h2);
    do_write(A_COUNT, 32'h0);
    do_write(A_CTRL, 32'h3);
    tick_n(2);
    do_write(A_COUNT, 32'h100);
    rd_chk(A_COUNT, 32'h100, "conflict_count");
    rd_chk(A_CTRL,  32'h6,   "conflict_a_ctrl");

    // Conflict B: W1C + enable write on the expire edge; set and enable win
    do_write(A_COUNT, 32'h0);
    do_write(A_CTRL, 32'h7);
    rd_chk(A_CTRL, 32'h3, "conflict_b_start");
    tick_n(2);
    do_write(A_CTRL, 32'h7);
    rd_chk(A_CTRL,  32'h7, "conflict_b_ctrl");
    rd_chk(A_COUNT, 32'h0, "conflict_b_count");
    do_write(A_CTRL, 32'h4);

    // Wrap: COUNT passes through 0xFFFFFFFF and 0 before matching VALUE=5
    do_write(A_VALUE, 32'h5);
    do_write(A_COUNT, 32'hFFFF_FFFE);
    do_write(A_CTRL, 32'h3);
    for (int k = 1; k <= 8; k++) begin
      tick_n(1);
      rd_chk(A_COUNT, (k == 8) ? 32'h0 : 32'hFFFF_FFFE + 32'(k),
             $sformatf("wrap_count_k%0d", k));
      rd_chk(A_CTRL, (k == 8) ? 32'h6 : 32'h3, $sformatf("wrap_ctrl_k%0d", k));
    end
    do_write(A_CTRL, 32'h4);

    // Reset while counting with the interrupt asserted and a write presented
    do_write(A_VALUE, 32'h1);
    do_write(A_COUNT, 32'h0);
    do_write(A_CTRL, 32'hB);
    tick_n(2);
    int_chk(1'b1, "rst_pre_int");
    rst    = 1'b1;
    wraddr = A_VALUE;
    wdata  = 32'hDEAD_BEEF;
    we     = 1'b1;
    tick_n(1);
    rst = 1'b0;
    we  = 1'b0;
    int_chk(1'b0, "rst_int");
    rd_chk(A_CTRL,  32'h0, "rst_ctrl");
    rd_chk(A_COUNT, 32'h0, "rst_count");
    rd_chk(A_VALUE, 32'h0, "rst_value");
    rd_chk(A_PSC,   32'h0, "rst_psc");

    // Randomized phase against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, d, ra;
      int sel;
      sel = int'($urandom_range(0, 6));
      case (sel)
        0, 5:    a = A_CTRL;
        1:       a = A_COUNT;
        2:       a = A_VALUE;
        3:       a = A_PSC;
        default: a = 32'h10 + 32'(4 * $urandom_range(0, 59));
      endcase
      a[1:0]  = 2'($urandom_range(0, 3));
      a[27:8] = 20'($urandom);
      d = $urandom;
      case (sel)
        0, 5: d[0] = ($urandom_range(0, 3) != 0);
        1:    d = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                              : 32'($urandom_range(0, 7));
        2:    d = 32'($urandom_range(0, 7));
        3:    d[15:0] = 16'($urandom_range(0, 3));
        default: ;
      endcase
      wraddr = a;
      wdata  = d;
      we     = ($urandom_range(0, 2) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
      we  = 1'b0;
      rst = 1'b0;
      ra  = {4'h0, 20'($urandom), 6'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      rd_chk(ra, model_read(ra), $sformatf("rand_rd_%0d", i));
      int_chk(m_reg[0][2] & m_reg[0][1], $sformatf("rand_int_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_rib_timer
`default_nettype wire

// File: doc/rib_timer.md
# rib_timer

Memory-mapped 32-bit timer that sits on the slave side of the RIB bus (the responder end of the master/slave interconnect), mapped as slave 3 at base 0x30000000. It decodes word accesses forwarded by the interconnect, with the top nibble already stripped, and serves reads combinationally in the same cycle. It runs a prescaled up-counter with compare/expire, one-shot or periodic mode, and a level interrupt towards the core.

## Interface
- No parameters. Register offsets are fixed constants (see Structure).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wraddr  in  32  read/write address from the interconnect; bits [31:28] are 0, only [7:0] decoded, [1:0] ignored.
- wdata  in  32  write data.
- we  in  1  write strobe; `WriteEnable` commits the write at the next rising edge.
- rdata  out  32  read data, combinational from wraddr and current register state.
- int_sig  out  1  interrupt, level, = pending & int_en.

## Operation
- Registers, all reset to 0:
  - CTRL at 0x00: bit0 enable, bit1 int_en, bit2 pending (write-1-to-clear), bit3 periodic. Bits [31:4] read 0.
  - COUNT at 0x04: 32-bit read/write counter.
  - VALUE at 0x08: 32-bit compare value.
  - PRESCALE at 0x0C: bits [15:0] read/write, bits [31:16] read 0.
- Unmapped offsets: read `ZeroWord`; writes are ignored.
- CTRL write: enable, int_en and periodic take wdata[0], wdata[1] and wdata[3]. pending is cleared only when wdata[2]=1; wdata[2]=0 leaves it unchanged.
- Internal psc_cnt is 16 bits. While enable=1, tick = (psc_cnt == PRESCALE).
  - On tick, psc_cnt resets to 0; otherwise psc_cnt increments.
  - While enable=0, psc_cnt holds at 0.
- On tick:
  - If COUNT == VALUE: expire. pending is set to 1 and COUNT resets to 0. If periodic=0, enable is cleared (one-shot).
  - Otherwise COUNT increments by 1, with 32-bit wrap.
- Priority in a single cycle:
  - A software write to COUNT beats a hardware increment or reset.
  - A software write to CTRL enable beats the one-shot auto-clear.
  - A hardware expire set beats a software W1C clear of pending. The event is never lost.
- VALUE=0: every tick expires.
- PRESCALE=0: every enabled cycle is a tick.
- Writing PRESCALE below the current psc_cnt has no special handling. psc_cnt counts up to 0xFFFF, wraps to 0, then matches.
- The block has no hold or handshake output. Every access completes in the cycle it is presented.

## Timing
- Reads are zero-latency. rdata reflects register values as of the last rising edge, not the write being presented in the same cycle.
- Writes are visible on rdata starting the cycle after the edge where we=1.
- Expire latency, with PRESCALE=P, VALUE=N and COUNT=0 at enable:
  - The first expire occurs (P+1)·(N+1) cycles after the edge that set enable.
  - int_sig rises on that same edge when int_en=1.
  - Periodic mode repeats every (P+1)·(N+1) cycles.
- int_sig is a registered-state function with no combinational path from wdata/we. It drops on the edge where pending is cleared.
- Reset asserted mid-count: on the next edge all registers, psc_cnt and int_sig are 0, regardless of we in that cycle.

## Structure
- Shared defines.v gets:
  - `TimerCtrl` 8'h00, `TimerCount` 8'h04, `TimerValue` 8'h08, `TimerPrescale` 8'h0C;
  - the CTRL bit indices;
  - a `slave_3` base nibble 4'b0011 for the interconnect decode.
- Existing `ZeroWord`, `WriteEnable` and `WriteDisable` are reused.
- No sub-module. One always block handles registers plus prescaler, and one combinational read mux; about 150 lines.

## Test plan
- Reset then read all four offsets and 0x10. Required: rdata=0 for every offset, int_sig=0.
- PRESCALE=0, VALUE=3, CTRL=0x3. Required: pending and int_sig rise exactly 4 cycles after the CTRL write edge, COUNT reads 0, CTRL reads 0x6 (one-shot cleared enable).
- PRESCALE=1, VALUE=2, CTRL=0xB. Required: expires every 6 cycles over 3 periods. Writing CTRL=0xF clears pending; int_sig drops the next cycle.
- Same-cycle conflict: at the expire cycle, write COUNT=0x100 and W1C pending. Required: COUNT reads 0x100 and pending reads 1.
- COUNT=0xFFFFFFFE, VALUE=0x5, PRESCALE=0, enable. Required: COUNT wraps through 0xFFFFFFFF, 0x0 … 0x5 before expiring.
- Assert rst while counting with int_sig=1 and we=1. Required: the next edge gives all registers 0 and int_sig 0, and the write is discarded.
